// File: rtl/mem_readback.sv
// Streams a block of RAM words out over a valid/ready port, wrapping addresses
// modulo 2^AWID, and keeps a running XOR of the transferred beats.
module mem_readback #(
  parameter int DWID = 8,
  parameter int AWID = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AWID-1:0] base_addr,
  input  logic [AWID:0]   len,
  output logic            busy,
  output logic            done,
  output logic [AWID-1:0] ram_addr,
  output logic            ram_wen,
  input  logic [DWID-1:0] ram_dout,
  output logic [DWID-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic [DWID-1:0] xsum
);

  localparam logic [AWID:0]   LEN_ONE  = (AWID+1)'(1);
  localparam logic [AWID-1:0] ADDR_ONE = AWID'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t          r_state, w_next;
  logic            w_issue, w_done_set, w_hs, w_room, w_out_free, w_fpop, w_fpush;
  logic [2:0]      w_occ;
  logic            r_s1, r_s2;
  logic [1:0]      r_fcnt;
  logic            r_fwr, r_frd;
  logic [DWID-1:0] r_fifo [2];
  logic [DWID-1:0] r_mdata, r_xsum;
  logic            r_mvalid, r_done;
  logic [AWID-1:0] r_ram_addr;
  logic [AWID:0]   r_addr_left, r_out_left;

  // The read round trip is two stages (address register, RAM data register), so
  // the output register and the 2-entry FIFO together give the three slots needed
  // to sustain one beat per cycle without ever overflowing.
  assign w_hs       = r_mvalid & m_ready;
  assign w_occ      = 3'(r_mvalid) + 3'(r_fcnt) + 3'(r_s1) + 3'(r_s2) - 3'(w_hs);
  assign w_room     = w_occ < 3'd3;
  assign w_out_free = ~r_mvalid | w_hs;
  assign w_fpop     = w_out_free & (r_fcnt != 2'd0);
  assign w_fpush    = r_s2 & ~(w_out_free & (r_fcnt == 2'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    w_done_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_done_set = 1'b1;
          end else begin
            w_issue = 1'b1;
            w_next  = (len == LEN_ONE) ? S_DRAIN : S_READ;
          end
        end
      end
      S_READ: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (r_addr_left == LEN_ONE) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_hs && m_last) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done      <= 1'b0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_ram_addr  <= '0;
      r_addr_left <= '0;
      r_out_left  <= '0;
      r_xsum      <= '0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_fwr       <= 1'b0;
      r_frd       <= 1'b0;
      r_fcnt      <= 2'd0;
      r_mdata     <= '0;
      r_mvalid    <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_s1   <= w_issue;
      r_s2   <= r_s1;
      if (w_issue) r_ram_addr <= (r_state == S_IDLE) ? base_addr : r_ram_addr + ADDR_ONE;

      if (r_state == S_IDLE && w_issue) begin
        r_addr_left <= len - LEN_ONE;
        r_out_left  <= len;
        r_xsum      <= '0;
      end else begin
        if (w_issue) r_addr_left <= r_addr_left - LEN_ONE;
        if (w_hs) begin
          r_out_left <= r_out_left - LEN_ONE;
          r_xsum     <= r_xsum ^ r_mdata;
        end
      end

      if (w_fpush) begin
        r_fifo[r_fwr] <= ram_dout;
        r_fwr         <= ~r_fwr;
      end
      if (w_fpop) r_frd <= ~r_frd;
      case ({w_fpush, w_fpop})
        2'b10:   r_fcnt <= r_fcnt + 2'd1;
        2'b01:   r_fcnt <= r_fcnt - 2'd1;
        default: r_fcnt <= r_fcnt;
      endcase

      // Older FIFO data has priority; fresh RAM data bypasses only an empty FIFO.
      if (w_fpop) begin
        r_mdata  <= r_fifo[r_frd];
        r_mvalid <= 1'b1;
      end else if (w_out_free && r_s2) begin
        r_mdata  <= ram_dout;
        r_mvalid <= 1'b1;
      end else if (w_hs) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign ram_addr = r_ram_addr;
  assign ram_wen  = 1'b0;
  assign m_data   = r_mdata;
  assign m_valid  = r_mvalid;
  assign m_last   = r_mvalid & (r_out_left == LEN_ONE);
  assign xsum     = r_xsum;

endmodule
